// File: rtl/pipe_adder.sv
// Pipelined two's-complement adder/subtractor: the carry chain is cut into STAGES
// equal slices, one slice per stage, behind a valid/ready stream handshake.
module pipe_adder #(
  parameter int WIDTH  = 32,  // >= 2
  parameter int STAGES = 4    // >= 1, must divide WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             Sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic             Cout,
  output logic             Over,
  output logic             Zero,
  output logic             Neg
);

  localparam int SW = WIDTH / STAGES;
  // Stages 0..STAGES-2 own internal registers; the last stage writes the output ports.
  localparam int PS = (STAGES > 1) ? STAGES - 1 : 1;

  // Internal stage registers (operands are carried forward for the upper slices).
  logic [WIDTH-1:0] a_q [PS];
  logic [WIDTH-1:0] b_q [PS];
  logic [WIDTH-1:0] r_q [PS];
  logic [PS-1:0]    c_q;
  logic [PS-1:0]    v_q;

  // Per-stage view of what each stage consumes and produces this cycle.
  logic [WIDTH-1:0] a_in      [STAGES];
  logic [WIDTH-1:0] b_in      [STAGES];
  logic [WIDTH-1:0] r_in      [STAGES];
  logic [WIDTH-1:0] r_nx      [STAGES];
  logic [SW:0]      slice_sum [STAGES];
  logic [STAGES-1:0] c_in;
  logic [STAGES-1:0] c_nx;
  logic [STAGES-1:0] v_in;

  logic stall;
  logic over_nx;

  assign stall    = out_valid && !out_ready;
  assign in_ready = !rst && !stall;

  // NOTE: every variable written here gets a value before any branch or loop
  // can skip it, so no path leaves a stale value and no latch is inferred.
  always_comb begin
    c_in = '0;
    v_in = '0;
    c_nx = '0;

    // Subtract is A + ~B + ~borrow, so B is inverted once at the entry.
    a_in[0] = A;
    b_in[0] = B ^ {WIDTH{Sub}};
    r_in[0] = '0;
    c_in[0] = Cin ^ Sub;
    v_in[0] = in_valid;

    for (int k = 1; k < STAGES; k++) begin
      a_in[k] = a_q[k-1];
      b_in[k] = b_q[k-1];
      r_in[k] = r_q[k-1];
      c_in[k] = c_q[k-1];
      v_in[k] = v_q[k-1];
    end

    for (int k = 0; k < STAGES; k++) begin
      slice_sum[k] = {1'b0, a_in[k][k*SW +: SW]}
                   + {1'b0, b_in[k][k*SW +: SW]}
                   + {{SW{1'b0}}, c_in[k]};
      r_nx[k]               = r_in[k];
      r_nx[k][k*SW +: SW]   = slice_sum[k][SW-1:0];
      c_nx[k]               = slice_sum[k][SW];
    end
  end

  // Carry into the MSB is recovered as a ^ b ^ sum at that bit position.
  assign over_nx = c_nx[STAGES-1]
                 ^ a_in[STAGES-1][WIDTH-1]
                 ^ b_in[STAGES-1][WIDTH-1]
                 ^ r_nx[STAGES-1][WIDTH-1];

  // NOTE: datapath stage registers have no reset; a clear valid bit marks their
  // contents as meaningless, so resetting them would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (!stall) begin
      for (int k = 0; k < STAGES - 1; k++) begin
        a_q[k] <= a_in[k];
        b_q[k] <= b_in[k];
        r_q[k] <= r_nx[k];
        c_q[k] <= c_nx[k];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all stages sample
  // the pre-edge values of their neighbours and shift together.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q       <= '0;
      out_valid <= 1'b0;
      Result    <= '0;
      Cout      <= 1'b0;
      Over      <= 1'b0;
      Zero      <= 1'b0;
      Neg       <= 1'b0;
    end else if (!stall) begin
      for (int k = 0; k < STAGES - 1; k++) begin
        v_q[k] <= v_in[k];
      end
      out_valid <= v_in[STAGES-1];
      // Bubbles leave the last result on the ports instead of stale slice data.
      if (v_in[STAGES-1]) begin
        Result <= r_nx[STAGES-1];
        Cout   <= c_nx[STAGES-1];
        Over   <= over_nx;
        Zero   <= (r_nx[STAGES-1] == '0);
        Neg    <= r_nx[STAGES-1][WIDTH-1];
      end
    end
  end

endmodule

// File: tb/tb_pipe_adder.sv
// Directed self-checking bench for pipe_adder (WIDTH=32, STAGES=4).
module tb_pipe_adder;

  localparam int W = 32;
  localparam int S = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Cin;
  logic         Sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] Result;
  logic         Cout;
  logic         Over;
  logic         Zero;
  logic         Neg;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipe_adder #(.WIDTH(W), .STAGES(S)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Cin       (Cin),
    .Sub       (Sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Result    (Result),
    .Cout      (Cout),
    .Over      (Over),
    .Zero      (Zero),
    .Neg       (Neg)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) step();
  endtask

  // Presents one operation for one cycle and waits (bounded) for its result.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, input logic sub,
                       output logic [W-1:0] res, output logic [3:0] flags,
                       output int lat);
    A = a; B = b; Cin = cin; Sub = sub;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    if (!out_valid) lat = -1;
    res   = Result;
    flags = {Cout, Over, Zero, Neg};
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    A = '0; B = '0; Cin = 1'b0; Sub = 1'b0;
    step();
    step();
    total++;
    if ({out_valid, Result, Cout, Over, Zero, Neg} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got valid=%b res=%h flags=%b%b%b%b want all zero",
               out_valid, Result, Cout, Over, Zero, Neg);
    end
    total++;
    if (in_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_in_ready got=%b want=0", in_ready);
    end
    rst = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL post_reset_in_ready got=%b want=1", in_ready);
    end
  endtask

  task automatic test_overflow();
    logic [W-1:0] res;
    logic [3:0]   fl;
    int           lat;
    do_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, res, fl, lat);
    total++;
    if (lat != 4) begin
      bad++;
      $display("FAIL ovf_latency got=%0d want=4", lat);
    end
    total++;
    if (res !== 32'h8000_0000) begin
      bad++;
      $display("FAIL ovf_result got=%h want=80000000", res);
    end
    total++;
    if (fl !== 4'b0101) begin
      bad++;
      $display("FAIL ovf_flags got=%b want=0101 (cout,over,zero,neg)", fl);
    end
  endtask

  task automatic test_carry();
    logic [W-1:0] res;
    logic [3:0]   fl;
    int           lat;
    do_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, res, fl, lat);
    total++;
    if (res !== 32'h0 || fl !== 4'b1010 || lat != 4) begin
      bad++;
      $display("FAIL carry_all got res=%h flags=%b lat=%0d want res=0 flags=1010 lat=4",
               res, fl, lat);
    end
    do_op(32'h0000_FFFF, 32'h0, 1'b1, 1'b0, res, fl, lat);
    total++;
    if (res !== 32'h0001_0000 || fl !== 4'b0000) begin
      bad++;
      $display("FAIL carry_cin got res=%h flags=%b want res=00010000 flags=0000", res, fl);
    end
  endtask

  task automatic test_subtract();
    logic [W-1:0] ta [4];
    logic [W-1:0] tb [4];
    logic         tc [4];
    logic [W-1:0] tr [4];
    logic [3:0]   tf [4];
    logic [W-1:0] res;
    logic [3:0]   fl;
    int           lat;
    ta[0] = 32'd5;          tb[0] = 32'd5; tc[0] = 1'b0; tr[0] = 32'h0;          tf[0] = 4'b1010;
    ta[1] = 32'd3;          tb[1] = 32'd5; tc[1] = 1'b0; tr[1] = 32'hFFFF_FFFE;  tf[1] = 4'b0001;
    ta[2] = 32'h8000_0000;  tb[2] = 32'd1; tc[2] = 1'b0; tr[2] = 32'h7FFF_FFFF;  tf[2] = 4'b1100;
    ta[3] = 32'd7;          tb[3] = 32'd2; tc[3] = 1'b1; tr[3] = 32'd4;          tf[3] = 4'b1000;
    for (int i = 0; i < 4; i++) begin
      do_op(ta[i], tb[i], tc[i], 1'b1, res, fl, lat);
      total++;
      if (res !== tr[i] || fl !== tf[i] || lat != 4) begin
        bad++;
        $display("FAIL sub_%0d got res=%h flags=%b lat=%0d want res=%h flags=%b lat=4",
                 i, res, fl, lat, tr[i], tf[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    int sent = 0;
    int got = 0;
    int stall_left = 0;
    bit started = 1'b0;
    drain();
    B = 32'd100; Cin = 1'b0; Sub = 1'b0;
    for (int cyc = 0; cyc < 80 && got < 10; cyc++) begin
      if (out_valid && !started) begin
        started = 1'b1;
        stall_left = 3;
      end
      out_ready = (stall_left == 0);
      in_valid  = (sent < 10);
      A = 32'(sent);
      #1;
      total++;
      if (in_ready !== (stall_left == 0)) begin
        bad++;
        $display("FAIL bp_in_ready cyc=%0d got=%b want=%b", cyc, in_ready, stall_left == 0);
      end
      if (stall_left > 0) begin
        total++;
        if (out_valid !== 1'b1 || Result !== 32'd100) begin
          bad++;
          $display("FAIL bp_hold cyc=%0d got valid=%b res=%h want valid=1 res=00000064",
                   cyc, out_valid, Result);
        end
        stall_left--;
      end else if (out_valid) begin
        total++;
        if (Result !== 32'(got + 100)) begin
          bad++;
          $display("FAIL bp_order idx=%0d got=%h want=%h", got, Result, 32'(got + 100));
        end
        got++;
      end
      if (in_valid && in_ready) sent++;
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    total++;
    if (got != 10) begin
      bad++;
      $display("FAIL bp_count got=%0d want=10", got);
    end
  endtask

  task automatic test_bubbles();
    logic exp_v;
    drain();
    B = '0; Cin = 1'b0; Sub = 1'b0;
    for (int c = 0; c < 12; c++) begin
      in_valid = (c < 4) && (c % 2 == 0);
      A = 32'(c + 10);
      #1;
      exp_v = (c >= 4) && (c < 8) && ((c - 4) % 2 == 0);
      total++;
      if (out_valid !== exp_v) begin
        bad++;
        $display("FAIL bubble_valid cyc=%0d got=%b want=%b", c, out_valid, exp_v);
      end
      if (exp_v) begin
        total++;
        if (Result !== 32'(c - 4 + 10)) begin
          bad++;
          $display("FAIL bubble_result cyc=%0d got=%h want=%h", c, Result, 32'(c - 4 + 10));
        end
      end
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    drain();
    B = 32'd1; Cin = 1'b0; Sub = 1'b0;
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1;
      A = 32'(c + 1);
      step();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset_in_ready got=%b want=0", in_ready);
    end
    step();
    total++;
    if ({out_valid, Result, Cout, Over, Zero, Neg} !== '0) begin
      bad++;
      $display("FAIL mid_reset_outputs got valid=%b res=%h want all zero", out_valid, Result);
    end
    rst = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL mid_after_in_ready got=%b want=1", in_ready);
    end
    for (int c = 0; c < 8; c++) begin
      step();
      total++;
      if ({out_valid, Result, Cout, Over, Zero, Neg} !== '0) begin
        bad++;
        $display("FAIL mid_no_result cyc=%0d got valid=%b res=%h want all zero",
                 c, out_valid, Result);
      end
    end
  endtask

  initial begin
    test_reset();
    test_overflow();
    test_carry();
    test_subtract();
    test_backpressure();
    test_bubbles();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule
